// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
//   trap_cause_t : reason a held instruction cannot retire normally.
//   wb_state_t   : stage control state (RUN / TRAP / FLUSH).
//   wb_entry_t   : the instruction fields held by the stage.
//   cause_of()   : classifies a held entry into a trap cause.
package wb_pkg;

  localparam int ADDR_WIDTH              = 32;
  localparam int DATA_WIDTH              = 32;
  localparam int NUM_REGISTERS           = 32;
  localparam int REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS);
  localparam int RETIRE_COUNT_WIDTH      = 64;

  typedef enum logic [1:0] {
    NONE       = 2'd0,
    ILLEGAL    = 2'd1,
    ENV        = 2'd2,
    BAD_RESULT = 2'd3
  } trap_cause_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    TRAP  = 2'd1,
    FLUSH = 2'd2
  } wb_state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]              pc;
    logic                               environment;
    logic                               opcode_legal;
    logic [REGISTER_INDEXING_WIDTH-1:0] write_register;
    logic                               writeback_enabled;
    logic [DATA_WIDTH-1:0]              result_data;
    logic                               result_data_valid;
  } wb_entry_t;

  // Priority: an illegal opcode outranks ecall/ebreak, which outranks a
  // missing result.
  function automatic trap_cause_t cause_of(input wb_entry_t e);
    trap_cause_t c;
    if (!e.opcode_legal) begin
      c = ILLEGAL;
    end else if (e.environment) begin
      c = ENV;
    end else if (e.writeback_enabled && !e.result_data_valid) begin
      c = BAD_RESULT;
    end else begin
      c = NONE;
    end
    return c;
  endfunction

endpackage

// File: rtl/writeback_stage_retire_counter.sv
// Wrapping retired-instruction counter.
//   clk, rst_n : clock, synchronous active-low reset
//   inc_en     : add one this cycle
//   count      : current count, wraps modulo 2^WIDTH
import wb_pkg::*;

module retire_counter #(
  parameter int WIDTH = RETIRE_COUNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_r;

  // Counter register; natural overflow provides the wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= {WIDTH{1'b0}};
    end else if (inc_en) begin
      count_r <= count_r + WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: holds one instruction from the memory stage, writes
// its result to the register file, raises precise traps and counts retires.
// Optional feature macro: WRITEBACK_RETIRE_COUNTER_EN (builds the retired
// instruction counter; otherwise retired_count reads 0).
// Ports:
//   upstream : prev_done, stall_prev, *_in instruction fields
//   regfile  : rf_write_ready, rf_write_en/addr/data
//   hazard   : instruction_writeback_register/enabled
//   trap     : trap_valid, trap_cause, trap_pc, trap_ack, flush
//   retire   : retire_valid, retired_count
import wb_pkg::*;

module writeback_stage (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               prev_done,
  output logic                               stall_prev,
  input  logic [ADDR_WIDTH-1:0]              program_count_in,
  input  logic                               program_count_valid_in,
  input  logic                               environment_in,
  input  logic                               opcode_legal_in,
  input  logic [REGISTER_INDEXING_WIDTH-1:0] write_register_in,
  input  logic                               writeback_enabled_in,
  input  logic [DATA_WIDTH-1:0]              result_data_in,
  input  logic                               result_data_valid_in,
  input  logic                               rf_write_ready,
  output logic                               rf_write_en,
  output logic [REGISTER_INDEXING_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0]              rf_write_data,
  output logic [REGISTER_INDEXING_WIDTH-1:0] instruction_writeback_register,
  output logic                               instruction_writeback_enabled,
  output logic                               trap_valid,
  output trap_cause_t                        trap_cause,
  output logic [ADDR_WIDTH-1:0]              trap_pc,
  input  logic                               trap_ack,
  output logic                               flush,
  output logic                               retire_valid,
  output logic [RETIRE_COUNT_WIDTH-1:0]      retired_count
);

  wb_state_t             state_r;
  wb_state_t             state_next_s;
  wb_entry_t             entry_r;
  logic                  has_input_r;
  logic                  trap_valid_r;
  trap_cause_t           trap_cause_r;
  logic [ADDR_WIDTH-1:0] trap_pc_r;

  trap_cause_t cause_s;
  logic        write_needed_s;
  logic        complete_s;
  logic        stall_s;
  logic        transfer_s;
  logic        env_retire_s;
  logic        retire_s;

  // Classify the held entry and derive the upstream handshake.
  always_comb begin
    cause_s        = cause_of(entry_r);
    // Writes to x0 are dropped, so they never wait on the register file.
    write_needed_s = entry_r.writeback_enabled &&
                     (entry_r.write_register != {REGISTER_INDEXING_WIDTH{1'b0}});
    complete_s     = (state_r == RUN) && has_input_r && (cause_s == NONE) &&
                     (!write_needed_s || rf_write_ready);
    stall_s        = !rst_n || (state_r != RUN) || (has_input_r && !complete_s);
    transfer_s     = prev_done && !stall_s;
    // ecall/ebreak retire when the handler takes the trap.
    env_retire_s   = (state_r == TRAP) && trap_ack && (trap_cause_r == ENV);
    retire_s       = rst_n && (complete_s || env_retire_s);
  end

  // Next-state logic for the trap sequencing.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN: begin
        if (has_input_r && (cause_s != NONE)) begin
          state_next_s = TRAP;
        end else begin
          state_next_s = RUN;
        end
      end
      TRAP: begin
        if (trap_ack) begin
          state_next_s = FLUSH;
        end else begin
          state_next_s = TRAP;
        end
      end
      FLUSH:   state_next_s = RUN;
      default: state_next_s = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Held entry, occupancy and latched trap information.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      has_input_r  <= 1'b0;
      entry_r      <= '0;
      trap_valid_r <= 1'b0;
      trap_cause_r <= NONE;
      trap_pc_r    <= {ADDR_WIDTH{1'b0}};
    end else begin
      if (state_r == FLUSH) begin
        has_input_r <= 1'b0;
      end else if (!has_input_r || complete_s) begin
        has_input_r <= transfer_s;
        if (transfer_s) begin
          entry_r <= '{pc:                program_count_in,
                       environment:       environment_in,
                       opcode_legal:      opcode_legal_in,
                       write_register:    write_register_in,
                       writeback_enabled: writeback_enabled_in,
                       result_data:       result_data_in,
                       result_data_valid: result_data_valid_in};
        end
      end

      if ((state_r == RUN) && has_input_r && (cause_s != NONE)) begin
        trap_valid_r <= 1'b1;
        trap_cause_r <= cause_s;
        trap_pc_r    <= entry_r.pc;
      end else if ((state_r == TRAP) && trap_ack) begin
        trap_valid_r <= 1'b0;
      end
    end
  end

  // Output decode; strobes are forced low while reset is asserted.
  always_comb begin
    stall_prev    = stall_s;
    rf_write_en   = rst_n && (state_r == RUN) && has_input_r &&
                    (cause_s == NONE) && write_needed_s;
    rf_write_addr = entry_r.write_register;
    rf_write_data = entry_r.result_data;
    instruction_writeback_register = entry_r.write_register;
    instruction_writeback_enabled  = has_input_r && entry_r.writeback_enabled &&
                                     (state_r == RUN);
    trap_valid    = rst_n && trap_valid_r;
    trap_cause    = trap_cause_r;
    trap_pc       = trap_pc_r;
    flush         = rst_n && (state_r == FLUSH);
    retire_valid  = retire_s;
  end

`ifdef WRITEBACK_RETIRE_COUNTER_EN
  retire_counter #(
    .WIDTH(RETIRE_COUNT_WIDTH)
  ) u_retire_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_en(retire_s),
    .count (retired_count)
  );
`else
  assign retired_count = {RETIRE_COUNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed scenarios followed by
// randomized traffic with random register-file backpressure and trap acks.
module tb_writeback_stage;
  import wb_pkg::*;

  localparam int RW = REGISTER_INDEXING_WIDTH;
  localparam int K_WRITE  = 0;
  localparam int K_RETIRE = 1;
  localparam int K_TRAP   = 2;
`ifdef WRITEBACK_RETIRE_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic prev_done = 1'b0;
  logic stall_prev;
  logic [31:0] program_count_in = 32'd0;
  logic program_count_valid_in = 1'b0;
  logic environment_in = 1'b0;
  logic opcode_legal_in = 1'b1;
  logic [RW-1:0] write_register_in = '0;
  logic writeback_enabled_in = 1'b0;
  logic [31:0] result_data_in = 32'd0;
  logic result_data_valid_in = 1'b0;
  logic rf_write_ready = 1'b0;
  logic rf_write_en;
  logic [RW-1:0] rf_write_addr;
  logic [31:0] rf_write_data;
  logic [RW-1:0] instruction_writeback_register;
  logic instruction_writeback_enabled;
  logic trap_valid;
  trap_cause_t trap_cause;
  logic [31:0] trap_pc;
  logic trap_ack = 1'b0;
  logic flush;
  logic retire_valid;
  logic [63:0] retired_count;

  writeback_stage dut (
    .clk(clk), .rst_n(rst_n), .prev_done(prev_done), .stall_prev(stall_prev),
    .program_count_in(program_count_in), .program_count_valid_in(program_count_valid_in),
    .environment_in(environment_in), .opcode_legal_in(opcode_legal_in),
    .write_register_in(write_register_in), .writeback_enabled_in(writeback_enabled_in),
    .result_data_in(result_data_in), .result_data_valid_in(result_data_valid_in),
    .rf_write_ready(rf_write_ready), .rf_write_en(rf_write_en),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .instruction_writeback_register(instruction_writeback_register),
    .instruction_writeback_enabled(instruction_writeback_enabled),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_ack(trap_ack), .flush(flush), .retire_valid(retire_valid),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [RW-1:0] addr;
    logic [31:0] data;
    trap_cause_t cause;
    logic [31:0] pc;
  } ev_t;

  ev_t exp_q[$];
  int  compared = 0;
  int  mismatched = 0;
  int  model_retires = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [63:0] exp_count(int n);
    return CNT_EN ? 64'(n) : 64'd0;
  endfunction

  // Register-file readiness and trap acknowledge, random or directed.
  bit rand_ready = 1'b0, manual_ready = 1'b1, rand_ack = 1'b0, manual_ack = 1'b0;
  always @(posedge clk) begin
    #2;
    rf_write_ready = rand_ready ? ($urandom_range(0, 1) == 1) : manual_ready;
    trap_ack       = rand_ack ? ($urandom_range(0, 3) == 0) : manual_ack;
  end

  // Monitor: matches observed writes / retires / traps against the queue.
  bit prev_tv = 1'b0, exp_flush = 1'b0;
  trap_cause_t cur_cause = NONE;
  always @(negedge clk) begin
    ev_t e;
    if (!rst_n) begin
      check("rst_stall", stall_prev, 64'd1);
      check("rst_strobes", {60'd0, rf_write_en, retire_valid, flush, trap_valid}, 64'd0);
      exp_q.delete();
      model_retires = 0;
      prev_tv = 1'b0;
      exp_flush = 1'b0;
    end else begin
      check("retired_count", retired_count, exp_count(model_retires));
      if (exp_flush) check("flush_pulse", flush, 64'd1);
      else if (flush) check("flush_unexpected", flush, 64'd0);
      if (flush) check("flush_stall", stall_prev, 64'd1);
      exp_flush = 1'b0;
      if (trap_valid) begin
        if (!prev_tv) begin
          check("trap_expected", exp_q.size() != 0, 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("trap_kind", 64'(K_TRAP), 64'(e.kind));
            check("trap_cause", trap_cause, e.cause);
            check("trap_pc", trap_pc, e.pc);
            cur_cause = e.cause;
          end
        end
        check("trap_no_write", rf_write_en, 64'd0);
        check("trap_stall", stall_prev, 64'd1);
        if (trap_ack) begin
          check("ack_retire", retire_valid, cur_cause == ENV);
          if (retire_valid) model_retires++;
          exp_flush = 1'b1;
        end else begin
          check("trap_hold_retire", retire_valid, 64'd0);
        end
      end else if (rf_write_en) begin
        check("write_expected", exp_q.size() != 0, 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          check("write_kind", 64'(K_WRITE), 64'(e.kind));
          check("write_addr", rf_write_addr, e.addr);
          check("write_data", rf_write_data, e.data);
          if (rf_write_ready) begin
            check("write_retire", retire_valid, 64'd1);
            void'(exp_q.pop_front());
            model_retires++;
          end else begin
            check("bp_stall", stall_prev, 64'd1);
            check("bp_retire", retire_valid, 64'd0);
          end
        end
      end else if (retire_valid) begin
        check("retire_expected", exp_q.size() != 0, 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("retire_kind", 64'(K_RETIRE), 64'(e.kind));
          model_retires++;
        end
      end
      prev_tv = trap_valid;
    end
  end

  // Present one instruction until accepted; push its expected outcome.
  task automatic issue(input logic [31:0] pc, input bit legal, input bit env,
                       input logic [RW-1:0] rd, input bit wb, input logic [31:0] data,
                       input bit dv, output int waits);
    ev_t e;
    bit acc;
    #1;
    prev_done = 1'b1;
    program_count_in = pc;
    program_count_valid_in = 1'b1;
    opcode_legal_in = legal;
    environment_in = env;
    write_register_in = rd;
    writeback_enabled_in = wb;
    result_data_in = data;
    result_data_valid_in = dv;
    waits = 0;
    acc = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      acc = !stall_prev;
      @(posedge clk);
      if (acc) begin
        if (!legal) e.cause = ILLEGAL;
        else if (env) e.cause = ENV;
        else if (wb && !dv) e.cause = BAD_RESULT;
        else e.cause = NONE;
        e.pc = pc;
        e.addr = rd;
        e.data = data;
        if (e.cause != NONE) e.kind = K_TRAP;
        else if (wb && rd != 0) e.kind = K_WRITE;
        else e.kind = K_RETIRE;
        exp_q.push_back(e);
        return;
      end
      waits++;
    end
    check("issue_accept", acc, 64'd1);
  endtask

  task automatic idle(input int n);
    #1;
    prev_done = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    int w;
    int base;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_trap_valid", trap_valid, 64'd0);
    check("reset_count", retired_count, 64'd0);
    check("reset_stall_release", stall_prev, 64'd0);
    check("reset_hazard_en", instruction_writeback_enabled, 64'd0);
    @(posedge clk);

    // Back-to-back writes x5..x8.
    manual_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(32'h1000 + 32'(4 * i), 1'b1, 1'b0, RW'(5 + i), 1'b1, 32'h10 + 32'(i), 1'b1, w);
      check("b2b_no_stall", 64'(w), 64'd0);
    end
    idle(3);
    check("b2b_count", retired_count, exp_count(4));

    // x0 writes retire without the register file.
    manual_ready = 1'b0;
    issue(32'h200, 1'b1, 1'b0, RW'(0), 1'b1, 32'hABC, 1'b1, w);
    issue(32'h204, 1'b1, 1'b0, RW'(0), 1'b1, 32'hABD, 1'b1, w);
    check("x0_no_stall", 64'(w), 64'd0);
    idle(2);

    // Backpressure on x3 for three cycles.
    manual_ready = 1'b0;
    issue(32'h300, 1'b1, 1'b0, RW'(3), 1'b1, 32'hDEADBEEF, 1'b1, w);
    #1 prev_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_stall_prev", stall_prev, 64'd1);
      check("bp_hazard_reg", instruction_writeback_register, 64'd3);
      check("bp_hazard_en", instruction_writeback_enabled, 64'd1);
      @(posedge clk);
    end
    manual_ready = 1'b1;
    issue(32'h304, 1'b1, 1'b0, RW'(4), 1'b1, 32'h44, 1'b1, w);
    check("bp_accept_same_cycle", 64'(w), 64'd0);
    idle(3);

    // Illegal opcode trap.
    base = model_retires;
    issue(32'h100, 1'b0, 1'b0, RW'(7), 1'b1, 32'h77, 1'b1, w);
    idle(3);
    @(negedge clk);
    check("ill_trap_valid", trap_valid, 64'd1);
    check("ill_cause", trap_cause, ILLEGAL);
    check("ill_pc", trap_pc, 64'h100);
    @(posedge clk);
    manual_ack = 1'b1;
    @(posedge clk);
    manual_ack = 1'b0;
    @(negedge clk);
    check("ill_flush", flush, 64'd1);
    @(posedge clk);
    idle(2);
    check("ill_count_unchanged", retired_count, exp_count(base));

    // ecall acknowledged in its first trap cycle.
    base = model_retires;
    issue(32'h400, 1'b1, 1'b1, RW'(0), 1'b0, 32'h0, 1'b0, w);
    #1 prev_done = 1'b0;
    @(posedge clk);
    manual_ack = 1'b1;
    @(negedge clk);
    check("env_trap_valid", trap_valid, 64'd1);
    check("env_retire_with_ack", retire_valid, 64'd1);
    @(posedge clk);
    manual_ack = 1'b0;
    @(negedge clk);
    check("env_flush", flush, 64'd1);
    @(posedge clk);
    idle(1);
    check("env_count", retired_count, exp_count(base + 1));

    // Reset while trapped.
    issue(32'h500, 1'b0, 1'b0, RW'(2), 1'b1, 32'h5, 1'b1, w);
    idle(2);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_trap_cleared", trap_valid, 64'd0);
    check("rst_count_cleared", retired_count, 64'd0);
    check("rst_stall_released", stall_prev, 64'd0);
    check("rst_no_flush", flush, 64'd0);
    @(posedge clk);

    // Randomized traffic.
    rand_ready = 1'b1;
    rand_ack = 1'b1;
    for (int n = 0; n < 300; n++) begin
      logic [RW-1:0] rd;
      rd = ($urandom_range(0, 7) == 0) ? RW'(0) : RW'($urandom_range(0, NUM_REGISTERS - 1));
      issue($urandom & 32'hFFFF_FFFC, $urandom_range(0, 15) != 0, $urandom_range(0, 15) == 0,
            rd, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 7) != 0, w);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
    end
    idle(40);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
